// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral register file clocked directly by the controller's sclk.
// Define SPI_PARITY_EN to append an odd-parity bit to every frame.
module spi_regfile_periph #(
    parameter int unsigned       NUM_REGS  = 5,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 7,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       sclk,
    input  logic                       rst_n,
    input  logic                       cs_n,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       parity_err
);

`ifdef SPI_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned HDR_LEN   = 1 + ADDR_W;
    localparam int unsigned FRAME_LEN = HDR_LEN + DATA_W + PAR_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {StCmd, StAddr, StData, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                in_range_q, in_range_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_bit;
    logic                par_ok;
    logic                commit;
    logic                frame_rst_n;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_shift_q;
    logic                oe_q;

    // cs_n high aborts the frame; registers and parity_err live on rst_n alone
    assign frame_rst_n = rst_n & ~cs_n;

    assign last_bit = (state_q == StData) && (cnt_q == CNT_W'(FRAME_LEN - 1));

`ifdef SPI_PARITY_EN
    logic par_q, par_d;

    // Running XOR over every sampled bit; odd parity means the total incl. parity is 1
    assign par_d  = (state_q == StCmd) ? copi : (par_q ^ copi);
    assign par_ok = par_d;

    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (last_bit && !par_ok) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        in_range_d = in_range_q;
        data_d     = data_q;
        commit     = 1'b0;
        case (state_q)
            StCmd: begin
                wr_d    = copi;
                cnt_d   = CNT_W'(1);
                state_d = StAddr;
            end
            StAddr: begin
                addr_d = ADDR_W'({addr_q, copi});
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ADDR_W)) begin
                    in_range_d = ({1'b0, addr_d} < NUM_REGS_A);
                    state_d    = StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q < CNT_W'(HDR_LEN + DATA_W)) begin
                    data_d = DATA_W'({data_q, copi});
                end
                if (last_bit) begin
                    commit  = wr_q && in_range_q && par_ok;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Counter saturates; edges ignored until cs_n rises
            end
            default: state_d = StCmd;
        endcase
    end

    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q    <= StCmd;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            in_range_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            in_range_q <= in_range_d;
            data_q     <= data_d;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= RESET_VAL;
            end
        end else if (commit) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (addr_q == ADDR_W'(r)) begin
                    regs_q[r] <= data_d;
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (in_range_q && (addr_q == ADDR_W'(r))) begin
                rd_word = regs_q[r];
            end
        end
    end

    // Read data launches on falling edges so the controller samples it on rising edges
    always_ff @(negedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            rd_shift_q <= '0;
            oe_q       <= 1'b0;
        end else if ((state_q == StData) && (cnt_q == CNT_W'(HDR_LEN)) && !wr_q) begin
            rd_shift_q <= rd_word;
            oe_q       <= 1'b1;
        end else if ((state_q == StData) && oe_q) begin
            rd_shift_q <= rd_shift_q << 1;
        end else if (state_q == StDone) begin
            oe_q <= 1'b0;
        end
    end

    assign cipo_oe = oe_q && (state_q != StDone);
    assign cipo    = cipo_oe & rd_shift_q[DATA_W-1];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Scoreboarded bench for spi_regfile_periph: directed frames then random frames
// against an array model; read data is collected by an independent cipo monitor.
module tb_spi_regfile_periph;

`ifdef SPI_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int FLEN   = 17;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int FLEN   = 16;
`endif

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        copi = 1'b0;
    logic        cipo;
    logic        cipo_oe;
    logic [39:0] regs_flat;
    logic        parity_err;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  model [5];
    logic        exp_perr = 1'b0;
    logic [7:0]  exp_q [$];
    logic [7:0]  got = '0;
    int          nbits_got = 0;

    spi_regfile_periph dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .copi       (copi),
        .cipo       (cipo),
        .cipo_oe    (cipo_oe),
        .regs_flat  (regs_flat),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model_flat();
        logic [39:0] f;
        for (int r = 0; r < 5; r++) f[r*8 +: 8] = model[r];
        return f;
    endfunction

    // Monitor: snapshot cipo just after each falling edge; a run of cipo_oe ends a read word
    always @(negedge sclk) begin
        #2;
        if (cipo_oe) begin
            got = {got[6:0], cipo};
            nbits_got++;
        end else if (nbits_got > 0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read_data: got %0h with no read pending", got);
            end else begin
                check("read_data", {56'd0, got}, {56'd0, exp_q.pop_front()});
                check("read_bits", nbits_got, 8);
            end
            nbits_got = 0;
        end
    end

    task automatic frame(input bit wr, input logic [6:0] addr, input logic [7:0] data,
                         input int nbits, input bit bad_par, input bit release_cs);
        logic [16:0] frm;
        logic        par;
        par = ~^{wr, addr, data};
        if (bad_par) par = ~par;
        frm = {wr, addr, data, par};
        if (!wr && nbits == FLEN) exp_q.push_back((addr < 5) ? model[addr] : 8'h00);
        cs_n = 1'b0;
        #3;
        for (int i = 0; i < nbits; i++) begin
            copi = frm[16-i];
            #2 sclk = 1'b1;
            #5 sclk = 1'b0;
            #3;
        end
        if (release_cs) begin
            #2 cs_n = 1'b1;
            #3;
        end
        if (nbits == FLEN) begin
            if (PAR_EN && bad_par) exp_perr = 1'b1;
            if (wr && addr < 5 && !(PAR_EN && bad_par)) model[addr] = data;
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_regs"}, {24'd0, regs_flat}, {24'd0, model_flat()});
        check({name, "_oe"}, cipo_oe, 0);
        check({name, "_cipo"}, cipo, 0);
        check({name, "_perr"}, parity_err, exp_perr);
    endtask

    initial begin
        for (int r = 0; r < 5; r++) model[r] = 8'h00;
        #20;
        check_idle("reset");
        rst_n = 1'b1;
        #10;

        frame(1'b1, 7'd2, 8'hA5, FLEN, 1'b0, 1'b1);
        check_idle("wr_a5");
        frame(1'b0, 7'd2, 8'h5A, FLEN, 1'b0, 1'b1);
        check_idle("rd_a5");
        frame(1'b1, 7'd5, 8'h3C, FLEN, 1'b0, 1'b1);
        check_idle("wr_oor");
        frame(1'b0, 7'd5, 8'hFF, FLEN, 1'b0, 1'b1);
        check_idle("rd_oor");
        frame(1'b1, 7'd1, 8'hFF, 10, 1'b0, 1'b1);
        check_idle("abort");
        frame(1'b1, 7'd1, 8'h11, FLEN, 1'b0, 1'b1);
        check_idle("wr_11");

        frame(1'b1, 7'd4, 8'h77, FLEN, 1'b0, 1'b1);
        check_idle("wr_77");
        frame(1'b1, 7'd3, 8'h99, 12, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        for (int r = 0; r < 5; r++) model[r] = 8'h00;
        exp_perr = 1'b0;
        #3;
        check_idle("mid_rst");
        rst_n = 1'b1;
        #2;
        // cs_n held low across the reset: the next bit must decode as a new R/W bit
        frame(1'b1, 7'd0, 8'h42, FLEN, 1'b0, 1'b1);
        check_idle("post_rst_wr");
        frame(1'b0, 7'd0, 8'h00, FLEN, 1'b0, 1'b1);
        check_idle("post_rst_rd");

`ifdef SPI_PARITY_EN
        frame(1'b1, 7'd3, 8'h01, FLEN, 1'b1, 1'b1);
        check_idle("bad_par");
        frame(1'b1, 7'd3, 8'h01, FLEN, 1'b0, 1'b1);
        check_idle("good_par");
`endif

        for (int n = 0; n < 80; n++) begin
            bit         wr;
            logic [6:0] addr;
            logic [7:0] data;
            int         nb;
            bit         bp;
            wr   = 1'($urandom_range(0, 1));
            addr = 7'($urandom_range(0, 7));
            data = 8'($urandom);
            nb   = (wr && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, FLEN - 1)) : FLEN;
            bp   = PAR_EN && ($urandom_range(0, 5) == 0);
            frame(wr, addr, data, nb, bp, 1'b1);
            check_idle("rand");
        end

        #20;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
